// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/ALU with optional MEM and REG_WRITE,
// plus wait timeout fault, boundary halt and retire/stall instrumentation.
module control_sequencer #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int          CNT_W      = 16,
    parameter bit          SKIP_EMPTY = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_needWait,
    input  logic             i_halt_req,
    input  logic             i_mem_op,
    input  logic             i_wb_op,
    output logic             o_fetch_en,
    output logic             o_decode_en,
    output logic             o_alu_en,
    output logic             o_mem_en,
    output logic             o_wb_en,
    output logic             o_incr_pc,
    output logic             o_retire,
    output logic             o_halted,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_retire_cnt,
    output logic [9:0]       o_dbg_state
);

    localparam int WCW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] LIMIT = WCW'(WAIT_LIMIT);
    localparam bit TIMEOUT_EN = (WAIT_LIMIT != 0);

    typedef enum logic [9:0] {
        S_FETCH     = 10'h001,
        S_DECODE    = 10'h002,
        S_ALU       = 10'h004,
        S_MEM       = 10'h008,
        S_REG_WRITE = 10'h010,
        S_HALT      = 10'h020,
        S_FAULT     = 10'h040
    } state_t;

    state_t           r_state;
    logic             r_memQ;
    logic             r_wbQ;
    logic [WCW-1:0]   r_waitCnt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_retireCnt;

    logic w_stage;
    logic w_waiting;
    logic w_advance;
    logic w_timeout;
    logic w_end;

    assign w_stage   = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_ALU) ||
                       (r_state == S_MEM) || (r_state == S_REG_WRITE);
    assign w_waiting = w_stage && i_needWait;
    assign w_advance = w_stage && !i_needWait;
    assign w_timeout = TIMEOUT_EN && w_waiting && (r_waitCnt == LIMIT);

    // An advance that leaves the last stage of the instruction retires it.
    always_comb begin
        w_end = 1'b0;
        if (w_advance) begin
            case (r_state)
                S_ALU:       w_end = !(r_memQ || !SKIP_EMPTY) && !r_wbQ;
                S_MEM:       w_end = !(r_wbQ || !SKIP_EMPTY);
                S_REG_WRITE: w_end = 1'b1;
                default:     w_end = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_FETCH;
            r_memQ      <= 1'b0;
            r_wbQ       <= 1'b0;
            r_waitCnt   <= '0;
            r_stallCnt  <= '0;
            r_retireCnt <= '0;
        end else begin
            if (w_waiting) begin
                r_waitCnt <= r_waitCnt + 1'b1;
                if (r_stallCnt != '1) begin
                    r_stallCnt <= r_stallCnt + 1'b1;
                end
            end else if (w_advance) begin
                r_waitCnt <= '0;
            end

            if (w_end) begin
                r_retireCnt <= r_retireCnt + 1'b1;
            end

            // Timeout only fires while still waiting, so an advance on the limit cycle wins.
            if (w_timeout) begin
                r_state <= S_FAULT;
            end else if (w_end) begin
                r_state <= i_halt_req ? S_HALT : S_FETCH;
            end else begin
                case (r_state)
                    S_FETCH: if (w_advance) r_state <= S_DECODE;
                    S_DECODE: begin
                        if (w_advance) begin
                            r_state <= S_ALU;
                            r_memQ  <= i_mem_op;
                            r_wbQ   <= i_wb_op;
                        end
                    end
                    S_ALU: begin
                        if (w_advance) begin
                            r_state <= (r_memQ || !SKIP_EMPTY) ? S_MEM : S_REG_WRITE;
                        end
                    end
                    S_MEM:  if (w_advance) r_state <= S_REG_WRITE;
                    S_HALT: if (!i_halt_req) r_state <= S_FETCH;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign o_fetch_en   = (r_state == S_FETCH);
    assign o_decode_en  = (r_state == S_DECODE);
    assign o_alu_en     = (r_state == S_ALU);
    assign o_mem_en     = (r_state == S_MEM) && r_memQ;
    assign o_wb_en      = (r_state == S_REG_WRITE) && r_wbQ;
    assign o_incr_pc    = (r_state == S_DECODE) && !i_needWait;
    assign o_retire     = w_end;
    assign o_halted     = (r_state == S_HALT);
    assign o_fault      = (r_state == S_FAULT);
    assign o_stall_cnt  = r_stallCnt;
    assign o_retire_cnt = r_retireCnt;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle sequencer for the CPU core, succeeding the three-phase fetch/decode/ALU controller. It steps each instruction through FETCH, DECODE, ALU, optional MEM and optional REG_WRITE, and emits one-hot stage enables plus the PC-increment strobe. It adds three features to the base stage sequencing:
- a wait-timeout fault;
- a clean halt at instruction boundaries;
- retire and stall instrumentation.

It sits between the datapath stage blocks and the memory interface, which drives `needWait`.

## Interface
Parameters:
- `WAIT_LIMIT`, default 255: consecutive wait cycles tolerated in one state before FAULT; 0 disables the timeout.
- `CNT_W`, default 16: width of `stall_cnt` and `retire_cnt`.
- `SKIP_EMPTY`, default 1:
  - 1: MEM and REG_WRITE are entered only when required.
  - 0: every instruction traverses all five stages, with unused enables gated low.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `needWait` in 1: holds the current state this cycle.
- `halt_req` in 1: request to stop at the next instruction boundary.
- `mem_op` in 1: from decode; instruction needs the MEM stage.
- `wb_op` in 1: from decode; instruction needs REG_WRITE.
- `fetch_en`, `decode_en`, `alu_en`, `mem_en`, `wb_en` out 1: stage enables.
- `incr_pc` out 1: single-cycle PC increment strobe.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `halted` out 1: sequencer is in HALT.
- `fault` out 1: sticky wait-timeout fault.
- `stall_cnt` out CNT_W: total waited cycles, saturating.
- `retire_cnt` out CNT_W: instructions retired, wrapping.
- `dbg_state` out 10: one-hot state vector.

## Operation
- State encoding (`dbg_state`) is one-hot:
  - FETCH=10'h001, DECODE=10'h002, ALU=10'h004, MEM=10'h008
  - REG_WRITE=10'h010, HALT=10'h020, FAULT=10'h040
- Stage enables are combinational decodes of state:
  - `fetch_en` = FETCH; `decode_en` = DECODE; `alu_en` = ALU.
  - `mem_en` = MEM & mem_q; `wb_en` = REG_WRITE & wb_q.
  - Enables stay asserted throughout wait cycles.
- `mem_op`/`wb_op` are latched into mem_q/wb_q on the DECODE→ALU advance. They are ignored at all other times.
- An "advance" is any cycle with needWait=0 in FETCH/DECODE/ALU/MEM/REG_WRITE. Transitions on advance:
  - FETCH→DECODE; DECODE→ALU.
  - ALU→MEM if (mem_q | !SKIP_EMPTY), else REG_WRITE if wb_q, else END.
  - MEM→REG_WRITE if (wb_q | !SKIP_EMPTY), else END.
  - REG_WRITE→END.
  - END = HALT if halt_req is 1 that cycle, else FETCH.
- `retire` is high on the cycle the END transition is taken. `retire_cnt` increments on that edge.
- `incr_pc` = DECODE & !needWait: exactly one pulse per instruction regardless of waits.
- Wait counter (internal):
  - Increments on each cycle with needWait=1 in a stage state.
  - Clears on every advance.
  - If WAIT_LIMIT≠0 and the counter equals WAIT_LIMIT while needWait=1, the next state is FAULT.
- `stall_cnt` increments on every waited cycle in a stage state and saturates at all-ones.
- HALT:
  - `halted`=1; all enables low; needWait ignored.
  - Exits to FETCH on the first cycle halt_req=0.
- FAULT:
  - `fault`=1; all enables low.
  - Left only by `rst`.
- `halt_req` never aborts an instruction in flight.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - state=FETCH.
  - Counters, mem_q, wb_q, wait counter = 0.
  - `fault`, `halted`, `retire`, `incr_pc` = 0.
  - `fetch_en`=1; `dbg_state`=10'h001.
- The first advance can occur on the first rising edge after `rst` deasserts.
- Latency with no waits, SKIP_EMPTY=1:
  - 3 cycles for ALU-only instructions; 4 with MEM or WB; 5 with both.
- SKIP_EMPTY=0: always 5 cycles.
- Each waited cycle adds exactly one cycle.
- A timeout is taken on the edge ending the (WAIT_LIMIT+1)th consecutive wait cycle. If needWait falls on that same cycle, the advance wins over the timeout.
- halt_req sampled high on the END cycle: HALT entered the next cycle, and `retire` still pulses.
- Counters are updated on the same edge as the state change.

## Test plan
- Reset then needWait=0, mem_op=wb_op=0 → `dbg_state` 001,002,004,001 repeating; `retire` every 3rd cycle; `incr_pc` once per instruction.
- mem_op=1, wb_op=1 → 001,002,004,008,010; `mem_en`/`wb_en` high in their stages; `retire_cnt`=1 after 5 cycles. Repeat with SKIP_EMPTY=0, mem_op=wb_op=0 → 5 states visited, `mem_en`/`wb_en` never high.
- needWait=1 for 4 cycles in DECODE → state held 5 cycles; `incr_pc` single pulse; `stall_cnt`=4.
- WAIT_LIMIT=3, needWait stuck high in FETCH → FAULT (10'h040) after 4 wait cycles; `fault` stays set; `rst` returns to FETCH.
- halt_req asserted mid-ALU → instruction completes with `retire`; state HALT, `halted`=1. Deassert halt_req → FETCH next cycle.
- `rst` pulse mid-MEM with needWait=1 → immediate FETCH; all counters 0.
